// File: rtl/regfile_mp_scoreboard.sv
// Multi-port register file with fixed-priority writes, busy scoreboard and saturating collision counter.
// Optional same-cycle write-to-read forwarding when RF_BYPASS_EN is defined.
module regfile_mp_scoreboard #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 4,
  parameter int NUM_WR   = 2,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     wr_conflict,
  output logic [CNT_W-1:0]         conflict_count
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] wr_hit;
  logic [NUM_REGS-1:0] rsv_hit;
  logic [DATA_W-1:0]   wr_val [NUM_REGS];
  logic                collide;
  logic                wr_conflict_q;
  logic [CNT_W-1:0]    conflict_count_q, conflict_count_d;
  logic [ADDR_W-1:0]   rd_a;

  // Register 0 and out-of-range addresses are not backed by storage.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a != '0) && (int'(a) < NUM_REGS);
  endfunction

  // Per-register write decode; the descending port scan leaves the lowest-index port as winner.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    wr_hit  = '0;
    rsv_hit = '0;
    collide = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) wr_val[r] = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      for (int w = NUM_WR - 1; w >= 0; w--) begin
        if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = wr_data[w*DATA_W +: DATA_W];
        end
      end
      rsv_hit[r] = rsv_en && (rsv_addr == ADDR_W'(r));
    end
    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        if (wr_en[i] && wr_en[j] && addr_ok(wr_addr[i*ADDR_W +: ADDR_W]) &&
            (wr_addr[i*ADDR_W +: ADDR_W] == wr_addr[j*ADDR_W +: ADDR_W]))
          collide = 1'b1;
      end
    end
  end

  // A new reservation outranks a writeback clear: the register has a fresh producer in flight.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (rsv_hit[r])     busy_d[r] = 1'b1;
      else if (wr_hit[r]) busy_d[r] = 1'b0;
    end
  end

  always_comb begin
    conflict_count_d = conflict_count_q;
    if (collide && (conflict_count_q != '1))
      conflict_count_d = conflict_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: this storage array is reset on purpose; a mid-run reset must clear architectural state.
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      busy_q           <= '0;
      wr_conflict_q    <= 1'b0;
      conflict_count_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers sample pre-edge values.
      for (int r = 1; r < NUM_REGS; r++) begin
        if (wr_hit[r]) regs_q[r] <= wr_val[r];
      end
      busy_q           <= busy_d;
      wr_conflict_q    <= collide;
      conflict_count_q <= conflict_count_d;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    rd_a    = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_a = rd_addr[p*ADDR_W +: ADDR_W];
      if (addr_ok(rd_a)) begin
`ifdef RF_BYPASS_EN
        if (wr_hit[rd_a]) begin
          rd_data[p*DATA_W +: DATA_W] = wr_val[rd_a];
          rd_busy[p]                  = rsv_hit[rd_a];
        end else
`endif
        begin
          rd_data[p*DATA_W +: DATA_W] = regs_q[rd_a];
          rd_busy[p]                  = busy_q[rd_a];
        end
      end
    end
  end

  assign wr_conflict    = wr_conflict_q;
  assign conflict_count = conflict_count_q;

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Bench for regfile_mp_scoreboard: directed vectors plus an array/counter model checked every cycle.
// A second instance with CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_regfile_mp_scoreboard;
  localparam int DW = 64, NR = 32, AW = 5, NRD = 4, NWR = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data, rd_data_s;
  logic [NRD-1:0]    rd_busy, rd_busy_s;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic              rsv_en;
  logic [AW-1:0]     rsv_addr;
  logic              wr_conflict, wr_conflict_s;
  logic [15:0]       conflict_count;
  logic [1:0]        conflict_count_s;

  int n_vec = 0;
  int n_bad = 0;

  regfile_mp_scoreboard #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(NRD),
                          .NUM_WR(NWR), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .wr_conflict(wr_conflict), .conflict_count(conflict_count));

  regfile_mp_scoreboard #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(NRD),
                          .NUM_WR(NWR), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_s), .rd_busy(rd_busy_s),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .wr_conflict(wr_conflict_s), .conflict_count(conflict_count_s));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Model state: register contents, busy flags, collision history.
  logic [DW-1:0] m_regs [NR];
  bit            m_busy [NR];
  bit            m_conf;
  int            m_cnt;
  int            hits [NR];

  function automatic bit valid(input int a);
    return a != 0 && a < NR;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NR; r++) begin m_regs[r] = '0; m_busy[r] = 0; end
      m_conf = 0;
      m_cnt  = 0;
    end else begin
      for (int r = 0; r < NR; r++) hits[r] = 0;
      for (int w = 0; w < NWR; w++) begin
        int a;
        a = int'(wr_addr[w*AW +: AW]);
        if (wr_en[w] && valid(a)) begin
          hits[a]++;
          if (hits[a] == 1) m_regs[a] = wr_data[w*DW +: DW];
        end
      end
      m_conf = 0;
      for (int r = 0; r < NR; r++) begin
        if (hits[r] >= 2) m_conf = 1;
        if (hits[r] > 0) m_busy[r] = 0;
      end
      if (rsv_en && valid(int'(rsv_addr))) m_busy[int'(rsv_addr)] = 1;
      if (m_conf) m_cnt++;
    end
  end

  // Compare every output against the model in mid-cycle.
  always @(negedge clk) begin
    for (int p = 0; p < NRD; p++) begin
      int a;
      logic [DW-1:0] ed;
      bit eb;
      a  = int'(rd_addr[p*AW +: AW]);
      ed = '0;
      eb = 0;
      if (valid(a)) begin
        ed = m_regs[a];
        eb = m_busy[a];
`ifdef RF_BYPASS_EN
        for (int w = NWR - 1; w >= 0; w--) begin
          if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == a) begin
            ed = wr_data[w*DW +: DW];
            eb = rsv_en && int'(rsv_addr) == a;
          end
        end
`endif
      end
      check($sformatf("cyc rd_data[%0d]", p), rd_data[p*DW +: DW], ed);
      check($sformatf("cyc rd_busy[%0d]", p), 64'(rd_busy[p]), 64'(eb));
      check($sformatf("cyc sat rd_data[%0d]", p), rd_data_s[p*DW +: DW], ed);
    end
    check("cyc wr_conflict", 64'(wr_conflict), 64'(m_conf));
    check("cyc conflict_count", 64'(conflict_count), 64'(m_cnt > 65535 ? 65535 : m_cnt));
    check("cyc sat conflict_count", 64'(conflict_count_s), 64'(m_cnt > 3 ? 3 : m_cnt));
  end

  task automatic idle();
    wr_en  = '0;
    rsv_en = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input int port, input int addr, input logic [DW-1:0] data);
    wr_en[port]            = 1'b1;
    wr_addr[port*AW +: AW] = AW'(addr);
    wr_data[port*DW +: DW] = data;
  endtask

  task automatic rsv(input int addr);
    rsv_en   = 1'b1;
    rsv_addr = AW'(addr);
  endtask

  task automatic rd(input int port, input int addr);
    rd_addr[port*AW +: AW] = AW'(addr);
  endtask

  initial begin
    reset   = 1'b1;
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    rsv_addr = '0;
    idle();
    #1;
    check("reset rd_data", rd_data[0 +: DW], 64'h0);
    check("reset count", 64'(conflict_count), 64'h0);
    @(negedge clk); #1;
    reset = 1'b0;

    // Two distinct addresses in one cycle: both commit, no collision.
    wr(0, 3, 64'h1111); wr(1, 7, 64'h2222);
    tick(); idle(); rd(0, 3); rd(1, 7); #1;
    check("dual write r3", rd_data[0 +: DW], 64'h1111);
    check("dual write r7", rd_data[DW +: DW], 64'h2222);
    check("dual write no conflict", 64'(wr_conflict), 64'h0);

    // Same address: port 0 wins, pulse for one cycle, count 1.
    wr(0, 9, 64'hAAAA); wr(1, 9, 64'hBBBB);
    tick(); idle(); rd(0, 9); #1;
    check("collide r9 winner", rd_data[0 +: DW], 64'hAAAA);
    check("collide pulse", 64'(wr_conflict), 64'h1);
    check("collide count", 64'(conflict_count), 64'h1);
    tick(); #1;
    check("collide pulse ends", 64'(wr_conflict), 64'h0);

    // Register 0 writes/reservations have no effect; invalid-address pairs do not collide.
    wr(0, 0, 64'hFFFF); wr(1, 0, 64'hFFFF); rsv(0);
    tick(); idle(); for (int p = 0; p < NRD; p++) rd(p, 0); #1;
    check("r0 reads zero", rd_data[2*DW +: DW], 64'h0);
    check("r0 not busy", 64'(rd_busy), 64'h0);
    check("r0 count unchanged", 64'(conflict_count), 64'h1);

    // Scoreboard: reserve, writeback clears, reserve+write keeps busy.
    rsv(12);
    tick(); idle(); rd(0, 12); #1;
    check("rsv r12 busy", 64'(rd_busy[0]), 64'h1);
    wr(0, 12, 64'h55);
    tick(); idle(); #1;
    check("wb r12 clears busy", 64'(rd_busy[0]), 64'h0);
    check("wb r12 data", rd_data[0 +: DW], 64'h55);
    rsv(12); wr(1, 12, 64'h55);
    tick(); idle(); #1;
    check("rsv+wb r12 busy", 64'(rd_busy[0]), 64'h1);
    check("rsv+wb r12 data", rd_data[0 +: DW], 64'h55);

    // Forwarding: same-cycle visibility only with bypass enabled.
    wr(0, 4, 64'h1234); rd(0, 4); #1;
`ifdef RF_BYPASS_EN
    check("bypass r4 same cycle", rd_data[0 +: DW], 64'h1234);
`else
    check("no bypass r4 old value", rd_data[0 +: DW], 64'h0);
`endif
    tick(); idle(); #1;
    check("r4 after edge", rd_data[0 +: DW], 64'h1234);

    // Four more collision cycles: wide counter 5, 2-bit counter sticks at 3.
    for (int i = 0; i < 4; i++) begin
      wr(0, 2, 64'(i)); wr(1, 2, 64'hDEAD);
      tick();
    end
    idle(); #1;
    check("count after 5 collisions", 64'(conflict_count), 64'h5);
    check("sat count sticks", 64'(conflict_count_s), 64'h3);

    // Mid-run asynchronous reset clears everything without a clock edge.
    wr(0, 5, 64'hA5); rsv(20);
    tick(); idle(); rd(0, 5); rd(1, 20); #1;
    check("r5 before reset", rd_data[0 +: DW], 64'hA5);
    check("r20 busy before reset", 64'(rd_busy[1]), 64'h1);
    reset = 1'b1; #1;
    check("async reset r5", rd_data[0 +: DW], 64'h0);
    check("async reset busy", 64'(rd_busy), 64'h0);
    check("async reset count", 64'(conflict_count), 64'h0);
    tick();
    reset = 1'b0;

    // Mixed traffic over a small address window to provoke collisions.
    for (int i = 0; i < 60; i++) begin
      wr_en    = NWR'($urandom_range(0, 3));
      wr_addr  = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      wr_data  = {64'($urandom), 64'($urandom)};
      rsv_en   = 1'($urandom_range(0, 1));
      rsv_addr = AW'($urandom_range(0, 7));
      for (int p = 0; p < NRD; p++) rd(p, $urandom_range(0, 7));
      tick();
    end
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
